dmem_subword_port: RTL and testbench

// - Byte-addressed load/store front end for the word-wide, 1-cycle-read BRAM data memory in the memory stage.
// - Converts LB/LH/LW/LBU/LHU/SB/SH/SW into BRAM word accesses.
// - Extracts and sign/zero-extends load lanes.
// - Performs read-modify-write for SB/SH, since the BRAM has no byte enables.
// - Sits between memory-stage control and the BRAM read/write ports.

---
 rtl/dmem_subword_port_pkg.sv | 24 ++
 rtl/dmem_subword_port_lane_unit.sv | 40 ++++
 rtl/dmem_subword_port.sv | 119 +++++++++++
 tb/tb_dmem_subword_port.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_subword_port_pkg.sv
// rtl/dmem_subword_port_pkg.sv - shared encodings and alignment check for the subword data-memory port
package dmem_subword_port_pkg;

    // Access size encodings as presented on req_size
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Port FSM state encodings
    localparam logic [1:0] STATE_IDLE      = 2'd0;
    localparam logic [1:0] STATE_LOAD_RESP = 2'd1;
    localparam logic [1:0] STATE_RMW_MERGE = 2'd2;

    // True when the access cannot be served: unaligned half/word or the reserved size code
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_SIZE_BYTE: isMisaligned = 1'b0;
            MEM_SIZE_HALF: isMisaligned = offset[0];
            MEM_SIZE_WORD: isMisaligned = (offset != 2'b00);
            default:       isMisaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_subword_port_lane_unit.sv
// rtl/dmem_subword_port_lane_unit.sv - combinational load-lane extraction and store-lane merge
module subword_lane_unit
    import dmem_subword_port_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [15:0]           wdata,
    input  logic [1:0]            offset,
    input  logic [1:0]            size,
    input  logic                  isUnsigned,
    output logic [DATA_WIDTH-1:0] extractData,
    output logic [DATA_WIDTH-1:0] mergeData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Pick the addressed lane out of the BRAM word and sign/zero-extend it
    always_comb begin
        byteLane = word[{offset, 3'b000} +: 8];
        halfLane = offset[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_SIZE_BYTE: extractData = {{(DATA_WIDTH-8){~isUnsigned & byteLane[7]}}, byteLane};
            MEM_SIZE_HALF: extractData = {{(DATA_WIDTH-16){~isUnsigned & halfLane[15]}}, halfLane};
            default:       extractData = word;
        endcase
    end

    // Replace only the target lane of the old word; half stores are already known aligned here
    always_comb begin
        mergeData = word;
        case (size)
            MEM_SIZE_BYTE: mergeData[{offset, 3'b000} +: 8] = wdata[7:0];
            MEM_SIZE_HALF: mergeData[{offset[1], 4'b0000} +: 16] = wdata;
            default:       mergeData = word;
        endcase
    end

endmodule

// File: rtl/dmem_subword_port.sv
// rtl/dmem_subword_port.sv - byte-addressed load/store front end for a word-wide 1-cycle BRAM
module dmem_subword_port
    import dmem_subword_port_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  bram_readEnable,
    output logic [ADDR_WIDTH-1:0] bram_readAddress,
    input  logic [DATA_WIDTH-1:0] bram_readData,
    output logic                  bram_writeEnable,
    output logic [ADDR_WIDTH-1:0] bram_writeAddress,
    output logic [DATA_WIDTH-1:0] bram_writeData
);

    logic [1:0]            state;
    logic [1:0]            nextState;
    logic [1:0]            capOffset;
    logic [1:0]            capSize;
    logic                  capUnsigned;
    logic [ADDR_WIDTH-1:0] capAddr;
    logic [15:0]           capWdata;
    logic                  errPending;

    logic [ADDR_WIDTH-1:0] reqWordAddr;
    logic [1:0]            reqOffset;
    logic                  accept;
    logic                  reqBad;
    logic                  acceptErr;
    logic                  acceptLoad;
    logic                  acceptWord;
    logic                  acceptSub;
    logic                  inMerge;
    logic [DATA_WIDTH-1:0] extractData;
    logic [DATA_WIDTH-1:0] mergeData;

    assign reqWordAddr = req_addr[ADDR_WIDTH+1:2];
    assign reqOffset   = req_addr[1:0];
    assign inMerge     = (state == STATE_RMW_MERGE);

    // The merge cycle owns the BRAM write port, so no request may be taken then
    assign req_ready  = reset & ~inMerge;
    assign accept     = req_valid & req_ready;
    assign reqBad     = isMisaligned(req_size, reqOffset);
    assign acceptErr  = accept & reqBad;
    assign acceptLoad = accept & ~reqBad & ~req_store;
    assign acceptWord = accept & ~reqBad & req_store & (req_size == MEM_SIZE_WORD);
    assign acceptSub  = accept & ~reqBad & req_store & (req_size != MEM_SIZE_WORD);

    // Loads and subword stores both need the current word; full-word stores write straight through
    assign bram_readEnable   = acceptLoad | acceptSub;
    assign bram_readAddress  = reqWordAddr;
    assign bram_writeEnable  = acceptWord | (reset & inMerge);
    assign bram_writeAddress = inMerge ? capAddr : reqWordAddr;
    assign bram_writeData    = inMerge ? mergeData : req_wdata;

    // Load data arrives from the BRAM during LOAD_RESP, so the response is formed combinationally then
    assign resp_valid = (state == STATE_LOAD_RESP) | errPending;
    assign resp_error = errPending;
    assign resp_rdata = (state == STATE_LOAD_RESP) ? extractData : '0;

    subword_lane_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .word        (bram_readData),
        .wdata       (capWdata),
        .offset      (capOffset),
        .size        (capSize),
        .isUnsigned  (capUnsigned),
        .extractData (extractData),
        .mergeData   (mergeData)
    );

    // Next state follows whatever request is accepted this cycle, else falls back to IDLE
    always_comb begin
        nextState = STATE_IDLE;
        if (acceptLoad) begin
            nextState = STATE_LOAD_RESP;
        end else if (acceptSub) begin
            nextState = STATE_RMW_MERGE;
        end
    end

    // State, error flag and request captures for the follow-up cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= STATE_IDLE;
            errPending  <= 1'b0;
            capOffset   <= 2'b00;
            capSize     <= 2'b00;
            capUnsigned <= 1'b0;
            capAddr     <= '0;
            capWdata    <= '0;
        end else begin
            state      <= nextState;
            errPending <= acceptErr;
            if (acceptLoad | acceptSub) begin
                capOffset   <= reqOffset;
                capSize     <= req_size;
                capUnsigned <= req_unsigned;
                capAddr     <= reqWordAddr;
                capWdata    <= req_wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_subword_port.sv
// tb/tb_dmem_subword_port.sv - self-checking bench with BRAM model and byte-level reference memory
module tb_dmem_subword_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        bram_readEnable;
    logic [7:0]  bram_readAddress;
    logic [31:0] bram_readData = '0;
    logic        bram_writeEnable;
    logic [7:0]  bram_writeAddress;
    logic [31:0] bram_writeData;

    always #5 clock = ~clock;

    dmem_subword_port #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_store         (req_store),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_error        (resp_error),
        .resp_rdata        (resp_rdata),
        .bram_readEnable   (bram_readEnable),
        .bram_readAddress  (bram_readAddress),
        .bram_readData     (bram_readData),
        .bram_writeEnable  (bram_writeEnable),
        .bram_writeAddress (bram_writeAddress),
        .bram_writeData    (bram_writeData)
    );

    // BRAM: 1-cycle registered read, same-cycle write forwarded to the read port
    logic [31:0] bramMem [0:255];
    always @(posedge clock) begin
        if (bram_writeEnable) bramMem[bram_writeAddress] <= bram_writeData;
        if (bram_readEnable) begin
            if (bram_writeEnable && bram_writeAddress == bram_readAddress)
                bram_readData <= bram_writeData;
            else
                bram_readData <= bramMem[bram_readAddress];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: plain byte-addressed little-endian memory
    logic [7:0]  refMem [0:1023];
    bit          expValid [int];
    bit          expErr [int];
    logic [31:0] expData [int];
    logic [31:0] gotData [int];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic uns, input int base);
        logic [31:0] v;
        logic [15:0] h;
        h = {refMem[base+1], refMem[base]};
        case (sz)
            2'b00:   v = uns ? {24'h0, refMem[base]} : {{24{refMem[base][7]}}, refMem[base]};
            2'b01:   v = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: v = {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
        endcase
        return v;
    endfunction

    // Every cycle out of reset: response must match what the reference predicted for that cycle
    always @(negedge clock) begin
        bit ev;
        if (reset) begin
            ev = expValid.exists(cyc);
            checkBit("resp_valid", resp_valid, ev);
            if (ev && resp_valid) begin
                checkBit("resp_error", resp_error, expErr[cyc]);
                check("resp_rdata", resp_rdata, expData[cyc]);
            end
            if (resp_valid) gotData[cyc] = resp_rdata;
        end
    end

    function automatic logic [31:0] got(input int k);
        return gotData.exists(k) ? gotData[k] : 32'hxxxx_xxxx;
    endfunction

    // Present a request until accepted; the reference is updated at acceptance
    task automatic doReq(input string name, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [9:0] a, input logic [31:0] wd, output int accCyc, output int stalls);
        int base;
        bit bad;
        base = int'(a);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        stalls = 0;
        accCyc = -1;
        for (int budget = 0; budget < 10; budget++) begin
            @(negedge clock);
            if (req_ready) begin
                accCyc = cyc;
                bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
                if (bad) begin
                    checkBit({name, " err no read"}, bram_readEnable, 1'b0);
                    checkBit({name, " err no write"}, bram_writeEnable, 1'b0);
                    expValid[cyc+1] = 1'b1; expErr[cyc+1] = 1'b1; expData[cyc+1] = 32'h0;
                end else if (!st) begin
                    checkBit({name, " load read"}, bram_readEnable, 1'b1);
                    check({name, " load raddr"}, {24'h0, bram_readAddress}, {24'h0, a[9:2]});
                    checkBit({name, " load no write"}, bram_writeEnable, 1'b0);
                    expValid[cyc+1] = 1'b1; expErr[cyc+1] = 1'b0;
                    expData[cyc+1] = modelLoad(sz, uns, base);
                end else begin
                    if (sz == 2'd2) begin
                        checkBit({name, " sw write"}, bram_writeEnable, 1'b1);
                        check({name, " sw waddr"}, {24'h0, bram_writeAddress}, {24'h0, a[9:2]});
                        check({name, " sw wdata"}, bram_writeData, wd);
                    end else begin
                        checkBit({name, " rmw read"}, bram_readEnable, 1'b1);
                        checkBit({name, " rmw no early write"}, bram_writeEnable, 1'b0);
                    end
                    for (int k = 0; k < (1 << sz); k++) refMem[base+k] = wd[8*k +: 8];
                end
                break;
            end else begin
                stalls++;
                checkBit({name, " merge write during stall"}, bram_writeEnable, 1'b1);
            end
        end
        if (accCyc < 0) begin
            checks++; failures++;
            $display("FAIL %s accept timeout", name);
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, s;
        for (int i = 0; i < 256; i++) bramMem[i] = '0;
        for (int i = 0; i < 1024; i++) refMem[i] = '0;

        // Reset held with a request pending
        reset = 1'b0; req_valid = 1'b1; req_size = 2'd2; req_addr = 10'h010;
        @(posedge clock); #1;
        repeat (3) begin
            @(negedge clock);
            checkBit("reset req_ready", req_ready, 1'b0);
            checkBit("reset readEnable", bram_readEnable, 1'b0);
            checkBit("reset writeEnable", bram_writeEnable, 1'b0);
            checkBit("reset resp_valid", resp_valid, 1'b0);
            @(posedge clock); #1;
        end
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        checkBit("ready after reset", req_ready, 1'b1);
        @(posedge clock); #1;

        // Sign/zero extension, back-to-back loads
        doReq("SW10", 1, 2'd2, 0, 10'h010, 32'h8000_80FF, a0, s);
        doReq("LB10", 0, 2'd0, 0, 10'h010, 32'h0, a0, s);
        doReq("LBU10", 0, 2'd0, 1, 10'h010, 32'h0, a1, s);
        doReq("LH12", 0, 2'd1, 0, 10'h012, 32'h0, a2, s);
        idle(); idle();
        check("LB10 literal", got(a0 + 1), 32'hFFFF_FFFF);
        check("LBU10 literal", got(a1 + 1), 32'h0000_00FF);
        check("LH12 literal", got(a2 + 1), 32'hFFFF_8000);
        check("loads back-to-back", a2 - a0, 2);

        // Read-modify-write byte and half
        doReq("SW20", 1, 2'd2, 0, 10'h020, 32'h1122_3344, a0, s);
        doReq("SB21", 1, 2'd0, 0, 10'h021, 32'h0000_00AA, a0, s);
        doReq("SH22", 1, 2'd1, 0, 10'h022, 32'h0000_BEEF, a0, s);
        check("SH22 stall cycles", s, 1);
        doReq("LW20", 0, 2'd2, 0, 10'h020, 32'h0, a0, s);
        check("LW20 stall cycles", s, 1);
        idle(); idle();
        check("LW20 literal", got(a0 + 1), 32'hBEEF_AA44);

        // Alignment / illegal size errors, including a store
        doReq("LH13", 0, 2'd1, 0, 10'h013, 32'h0, a0, s);
        doReq("LW22", 0, 2'd2, 0, 10'h022, 32'h0, a1, s);
        doReq("SZ3", 0, 2'd3, 0, 10'h020, 32'h0, a2, s);
        doReq("SWbad", 1, 2'd2, 0, 10'h022, 32'hDEAD_DEAD, a2, s);
        doReq("LW20b", 0, 2'd2, 0, 10'h020, 32'h0, a2, s);
        idle(); idle();
        check("LH13 err rdata", got(a0 + 1), 32'h0);
        check("LW20 after errors", got(a2 + 1), 32'hBEEF_AA44);

        // SB then immediate LW: write-then-read ordering
        doReq("SW30", 1, 2'd2, 0, 10'h030, 32'hCAFE_F00D, a0, s);
        doReq("SB30", 1, 2'd0, 0, 10'h030, 32'h0000_0077, a0, s);
        doReq("LW30", 0, 2'd2, 0, 10'h030, 32'h0, a1, s);
        check("LW30 stall cycles", s, 1);
        idle(); idle();
        check("LW30 literal", got(a1 + 1), 32'hCAFE_F077);

        // Reset during the merge cycle of SH @0x40 abandons the write
        doReq("SW40", 1, 2'd2, 0, 10'h040, 32'h1234_5678, a0, s);
        idle();
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 10'h040; req_wdata = 32'h0000_9999;
        @(negedge clock);
        checkBit("SH40 accepted", req_ready, 1'b1);
        checkBit("SH40 read", bram_readEnable, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        checkBit("SH40 merge write suppressed", bram_writeEnable, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checkBit("ready after merge reset", req_ready, 1'b1);
        @(posedge clock); #1;
        doReq("LW40", 0, 2'd2, 0, 10'h040, 32'h0, a0, s);
        idle(); idle();
        check("LW40 literal", got(a0 + 1), 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
